reg_file_sb: RTL and testbench

- Parametrised successor to the 16x32 two-read/one-write register file.
- Generalises data width, depth and read-port count, and adds an optional registered read stage and write-through bypass.
- Adds a hardwired-zero register and a per-register busy scoreboard, so the pipeline can track outstanding writes and stall on read-after-write hazards.
- Sits between decode (read/claim) and writeback (write) in the CPU datapath.

---
 rtl/reg_file_sb.sv | 119 +++++++++++
 tb/tb_reg_file_sb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised multi-port register file with write-through bypass, optional
// registered read stage, hardwired-zero register and per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int READ_LAT = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              claim_ok;

  logic [NUM_RD*DATA_W-1:0] rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_d;

  always_comb begin
    wr_ok    = wr_en    && !(HAS_ZERO && (wr_addr == '0));
    claim_ok = claim_en && !(HAS_ZERO && (claim_addr == '0));
  end

  // Claim is applied after the write clear so a same-edge claim wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Per-port read mux: hardwired zero, then bypass from the write port, then array.
  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              hit;
    rd_data_d = '0;
    rd_busy_d = '0;
    ra        = '0;
    is_zero   = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra      = rd_addr[i*ADDR_W +: ADDR_W];
      is_zero = HAS_ZERO && (ra == '0);
      hit     = wr_ok && (wr_addr == ra);
      if (is_zero) begin
        rd_data_d[i*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rd_data_d[i*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data_d[i*DATA_W +: DATA_W] = regs_q[ra];
      end
      rd_busy_d[i] = !is_zero && busy_q[ra] && !hit;
    end
  end

  generate
    if (READ_LAT == 1) begin : g_rd_reg
      logic [NUM_RD*DATA_W-1:0] rd_data_q;
      logic [NUM_RD-1:0]        rd_busy_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data_q <= '0;
          rd_busy_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
          rd_busy_q <= rd_busy_d;
        end
      end

      assign rd_data = rd_data_q;
      assign rd_busy = rd_busy_q;
    end else begin : g_rd_comb
      assign rd_data = rd_data_d;
      assign rd_busy = rd_busy_d;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: combinational/zero-reg, registered/no-zero-reg
// and 3-port 16-bit instances share one stimulus stream.
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic [7:0]  ra;
  logic [11:0] ra2;

  logic [63:0] rd0, rd1;
  logic [47:0] rd2;
  logic [1:0]  rb0, rb1;
  logic [2:0]  rb2;
  logic [15:0] bv0, bv1, bv2;

  int vectors;
  int miscompares;

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .READ_LAT(0), .ZERO_REG(1)) u_d0 (
    .clk(clk), .reset(reset), .rd_addr(ra), .rd_data(rd0), .rd_busy(rb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(bv0)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .READ_LAT(1), .ZERO_REG(0)) u_d1 (
    .clk(clk), .reset(reset), .rd_addr(ra), .rd_data(rd1), .rd_busy(rb1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(bv1)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .READ_LAT(0), .ZERO_REG(1)) u_d2 (
    .clk(clk), .reset(reset), .rd_addr(ra2), .rd_data(rd2), .rd_busy(rb2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(bv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    ra         = '0;
    ra2        = '0;

    // reset before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_d0_data", rd0, 64'h0);
    chk("rst_d0_busyvec", bv0, 16'h0);
    chk("rst_d1_data_noclk", rd1, 64'h0);
    chk("rst_d1_busy_noclk", rb1, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d2_data", rd2, 48'h0);
    reset = 1'b1;

    // write reg3, bypass then array read on both ports
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; ra = {4'd3, 4'd3};
    #1 chk("byp_d0_r3", rd0, {32'hDEADBEEF, 32'hDEADBEEF});
    @(negedge clk);
    wr_en = 1'b0;
    #1 chk("rd_d0_r3", rd0, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("rd_d1_r3", rd1, {32'hDEADBEEF, 32'hDEADBEEF});

    // bypass of reg5: immediate on d0, one cycle later on d1
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678; ra = {4'd3, 4'd5};
    #1 chk("byp_d0_r5", rd0, {32'hDEADBEEF, 32'h12345678});
    chk("byp_d1_r5_pre", rd1, {32'hDEADBEEF, 32'hDEADBEEF});
    @(posedge clk);
    #1 chk("byp_d1_r5_post", rd1, {32'hDEADBEEF, 32'h12345678});
    wr_en = 1'b0;

    // zero register: write + claim reg0
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = 4'd0; ra = {4'd0, 4'd0};
    #1 chk("zr_d0_byp", rd0, 64'h0);
    @(negedge clk);
    wr_en = 1'b0; claim_en = 1'b0;
    #1 chk("zr_d0_data", rd0, 64'h0);
    chk("zr_d0_rbusy", rb0, 2'b00);
    chk("zr_d0_bv0", bv0[0], 1'b0);
    chk("nzr_d1_bv0", bv1[0], 1'b1);
    chk("nzr_d1_data", rd1, {32'hFFFFFFFF, 32'hFFFFFFFF});
    chk("nzr_d1_rbusy_byp", rb1, 2'b00);
    @(posedge clk);
    #1 chk("nzr_d1_rbusy", rb1, 2'b11);
    chk("nzr_d1_data2", rd1, {32'hFFFFFFFF, 32'hFFFFFFFF});

    // scoreboard on reg7
    @(negedge clk);
    claim_en = 1'b1; claim_addr = 4'd7; ra = {4'd7, 4'd7};
    #1 chk("sb_claim_same_cyc", rb0, 2'b00);
    @(negedge clk);
    claim_en = 1'b0;
    #1 chk("sb_bv_r7", bv0, 16'h0080);
    chk("sb_rbusy_r7", rb0, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000055;
    #1 chk("sb_wr_clears", rb0, 2'b00);
    chk("sb_wr_byp", rd0, {32'h55, 32'h55});
    @(posedge clk);
    #1 chk("sb_bv_clear", bv0, 16'h0000);
    wr_en = 1'b0;

    // simultaneous claim and write on reg9
    @(negedge clk);
    wr_en = 1'b1; claim_en = 1'b1; wr_addr = 4'd9; claim_addr = 4'd9;
    wr_data = 32'hA5A50009; ra = {4'd9, 4'd9};
    @(negedge clk);
    wr_en = 1'b0; claim_en = 1'b0;
    #1 chk("wc_r9_data", rd0, {32'hA5A50009, 32'hA5A50009});
    chk("wc_r9_bv", bv0, 16'h0200);
    chk("wc_r9_rbusy", rb0, 2'b11);

    // fill regs 1..15 with their index, claim reg12, then mid-run reset
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'(i);
    end
    @(negedge clk);
    wr_en = 1'b0; claim_en = 1'b1; claim_addr = 4'd12;
    @(negedge clk);
    claim_en = 1'b0; ra = {4'd3, 4'd5}; ra2 = {4'd15, 4'd7, 4'd1};
    #1 chk("fill_d2", rd2, {16'd15, 16'd7, 16'd1});
    chk("fill_d0", rd0, {32'd3, 32'd5});
    chk("fill_bv", bv0, 16'h1000);
    reset = 1'b0;
    #1 chk("mrst_d2", rd2, 48'h0);
    chk("mrst_d0", rd0, 64'h0);
    chk("mrst_bv", bv0, 16'h0);
    chk("mrst_d1", rd1, 64'h0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 chk("post_mrst_d0", rd0, 64'h0);
    chk("post_mrst_d2", rd2, 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
